regfile_writeback: RTL and testbench
====================================

// Module: regfile_writeback
// PURPOSE
//  Write-side master for the 32x32 register file: accepts results from two producers (ALU, memory/mul unit)
//  over valid/ready, arbitrates, and drives the regfile write port through one registered stage.
//  Keeps a pending-write scoreboard so decode can stall on RAW/WAW hazards.
//  Sits between execute/memory stages and the regfile.
// PARAMETERS
//  XLEN          32  data width of results and regfile write data
//  REG_ADDR_W    5   register address width (2**REG_ADDR_W registers)
//  STARVE_LIMIT  4   consecutive lost arbitrations after which src1 gets priority for one grant
// PORTS
//  clk             in   1           clock; all state updates on posedge
//  rst             in   1           synchronous, active-high reset
//  src0_valid      in   1           ALU result valid
//  src0_ready      out  1           ALU result accepted this cycle
//  src0_rd         in   REG_ADDR_W  ALU destination register
//  src0_data       in   XLEN        ALU result
//  src1_valid      in   1           mem/mul result valid
//  src1_ready      out  1           mem/mul result accepted this cycle
//  src1_rd         in   REG_ADDR_W  mem/mul destination register
//  src1_data       in   XLEN        mem/mul result
//  iss_valid       in   1           decode issuing an instruction that will write iss_rd
//  iss_ready       out  1           issue accepted (0 = WAW stall)
//  iss_rd          in   REG_ADDR_W  destination of issuing instruction
//  rf_write_enable out  1           regfile write strobe
//  rf_write_addr   out  REG_ADDR_W  regfile write address
//  rf_data_in      out  XLEN        regfile write data
//  pending         out  2**REG_ADDR_W  bit i = register i has an outstanding write
// BEHAVIOUR
//  Reset: rf_write_enable=0, rf_write_addr=0, rf_data_in=0, pending=0, starve count=0.
//   src*_ready and iss_ready are 0 while rst is high. Reset mid-operation drops any held write.
//  Arbitration (combinational ready, one grant per cycle): default src0 priority.
//   If starve count == STARVE_LIMIT and src1_valid, src1 wins and counter clears.
//   Starve count increments when src1_valid && src0_valid && src0 granted; clears on src1 grant; saturates.
//   Loser sees ready=0 and must hold valid/rd/data stable (no drop, no reorder within a source).
//  Write stage: granted beat registers into rf_write_* on the next edge; latency accept -> strobe = 1 cycle.
//   Output register is unconditionally overwritten each cycle; no backpressure from regfile.
//   rd==0: beat is accepted, rf_write_enable stays 0 (x0 never written), data discarded.
//  Scoreboard:
//   iss_ready = !rst && (iss_rd==0 || !pending[iss_rd]).
//   Set: iss_valid && iss_ready && iss_rd!=0 -> pending[iss_rd]=1 next cycle.
//   Clear: on the edge where rf_write_enable=1, pending[rf_write_addr]=0, so a reader seeing
//    pending=0 is guaranteed the regfile already holds the value (asynchronous regfile read).
//   Same register set and cleared on one edge: set wins (result pending=1).
//   pending[0] is constant 0. Completion for a non-pending register is legal, no effect on other bits.
//  Both sources writing the same rd in consecutive cycles: write order = grant order.
// STRUCTURE
//  Package wb_pkg: XLEN, REG_ADDR_W, NUM_REGS, src_sel_e {SRC_ALU, SRC_MEM}, wb_beat_t {rd, data}.
//  Sub-module wb_scoreboard (pending vector, set/clear, iss_ready); arbiter + write register in top.
// TESTING
//  1 rst high 3 cycles with src0/src1/iss valid -> all readies 0, rf_write_enable 0, pending 0.
//  2 src0 rd=5 data=0xDEADBEEF in cycle t -> rf_write_enable=1 addr=5 data=0xDEADBEEF in t+1 only.
//  3 iss rd=7, then iss rd=7 again -> second iss_ready=0 until cycle after write to r7; pending[7] 1->0.
//  4 src0 and src1 both valid 6 cycles (rd 1/2) -> grants src0 x4, src1 on 5th, src0 6th; src1 data held intact.
//  5 src1 rd=0 data=0x1234 -> src1_ready=1, rf_write_enable stays 0, pending unchanged.
//  6 write r3 completing while iss rd=3 same cycle (pending[3]=1 before) -> iss_ready=0; next cycle iss_ready=1,
//    then issue+completion same edge on r3 -> pending[3]=1; rst mid-write -> pending=0, no strobe.

Source files
------------

// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared widths, source select and beat type for the writeback block
package wb_pkg;
    localparam int XLEN              = 32;
    localparam int REG_ADDR_W        = 5;
    localparam int NUM_REGS          = 2 ** REG_ADDR_W;
    localparam int STARVE_LIMIT_DFLT = 4;

    typedef enum logic {SRC_ALU, SRC_MEM} src_sel_e;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       data;
    } wb_beat_t;
endpackage

// File: rtl/regfile_writeback_scoreboard.sv
// rtl/regfile_writeback_scoreboard.sv - pending-write scoreboard gating issue on WAW hazards
module wb_scoreboard
    import wb_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  iss_valid,
    input  logic [REG_ADDR_W-1:0] iss_rd,
    output logic                  iss_ready,
    input  logic                  clr_en,
    input  logic [REG_ADDR_W-1:0] clr_addr,
    output logic [NUM_REGS-1:0]   pending
);
    logic [NUM_REGS-1:0] pending_next;

    assign iss_ready = !rst && ((iss_rd == '0) || !pending[iss_rd]);

    // Clear is applied first so a same-edge issue to the same register wins.
    always_comb begin
        pending_next = pending;
        if (clr_en)
            pending_next[clr_addr] = 1'b0;
        if (iss_valid && iss_ready && (iss_rd != '0))
            pending_next[iss_rd] = 1'b1;
        pending_next[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst)
            pending <= '0;
        else
            pending <= pending_next;
    end
endmodule

// File: rtl/regfile_writeback.sv
// rtl/regfile_writeback.sv - two-source writeback arbiter driving the regfile write port
module regfile_writeback
    import wb_pkg::*;
#(
    parameter int STARVE_LIMIT = STARVE_LIMIT_DFLT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  src0_valid,
    output logic                  src0_ready,
    input  logic [REG_ADDR_W-1:0] src0_rd,
    input  logic [XLEN-1:0]       src0_data,
    input  logic                  src1_valid,
    output logic                  src1_ready,
    input  logic [REG_ADDR_W-1:0] src1_rd,
    input  logic [XLEN-1:0]       src1_data,
    input  logic                  iss_valid,
    output logic                  iss_ready,
    input  logic [REG_ADDR_W-1:0] iss_rd,
    output logic                  rf_write_enable,
    output logic [REG_ADDR_W-1:0] rf_write_addr,
    output logic [XLEN-1:0]       rf_data_in,
    output logic [NUM_REGS-1:0]   pending
);
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

    logic [CNT_W-1:0] starve_cnt;
    logic             starved;
    logic             wb_valid;
    src_sel_e         sel;
    wb_beat_t         beat;

    // src0 wins by default; src1 is forced through once it has lost STARVE_LIMIT times in a row.
    assign starved    = (starve_cnt == CNT_W'(STARVE_LIMIT)) && src1_valid;
    assign src0_ready = !rst && src0_valid && !starved;
    assign src1_ready = !rst && src1_valid && !src0_ready;
    assign wb_valid   = src0_ready || src1_ready;
    assign sel        = src1_ready ? SRC_MEM : SRC_ALU;

    always_comb begin
        beat = '0;
        case (sel)
            SRC_ALU: beat = '{rd: src0_rd, data: src0_data};
            SRC_MEM: beat = '{rd: src1_rd, data: src1_data};
            default: beat = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)
            starve_cnt <= '0;
        else if (src1_ready)
            starve_cnt <= '0;
        else if (src0_ready && src1_valid && (starve_cnt != CNT_W'(STARVE_LIMIT)))
            starve_cnt <= starve_cnt + 1'b1;
    end

    // Writes to x0 are accepted but never strobed.
    always_ff @(posedge clk) begin
        if (rst) begin
            rf_write_enable <= 1'b0;
            rf_write_addr   <= '0;
            rf_data_in      <= '0;
        end else begin
            rf_write_enable <= wb_valid && (beat.rd != '0);
            rf_write_addr   <= beat.rd;
            rf_data_in      <= beat.data;
        end
    end

    wb_scoreboard u_scoreboard (
        .clk      (clk),
        .rst      (rst),
        .iss_valid(iss_valid),
        .iss_rd   (iss_rd),
        .iss_ready(iss_ready),
        .clr_en   (rf_write_enable),
        .clr_addr (rf_write_addr),
        .pending  (pending)
    );
endmodule

// File: tb/tb_regfile_writeback.sv
// tb/tb_regfile_writeback.sv - directed and randomized checks of regfile_writeback against a reference model
module tb_regfile_writeback;
    logic        clk = 1'b0;
    logic        rst;
    logic        src0_valid, src0_ready, src1_valid, src1_ready;
    logic [4:0]  src0_rd, src1_rd, iss_rd, rf_write_addr;
    logic [31:0] src0_data, src1_data, rf_data_in, pending;
    logic        iss_valid, iss_ready, rf_write_enable;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] m_pending;
    int          m_lost;
    logic        m_wen;
    logic [4:0]  m_waddr;
    logic [31:0] m_wdata;
    logic        acc0, acc1;
    logic        d_r0, d_r1, d_iss;

    regfile_writeback dut (
        .clk(clk), .rst(rst),
        .src0_valid(src0_valid), .src0_ready(src0_ready), .src0_rd(src0_rd), .src0_data(src0_data),
        .src1_valid(src1_valid), .src1_ready(src1_ready), .src1_rd(src1_rd), .src1_data(src1_data),
        .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_rd(iss_rd),
        .rf_write_enable(rf_write_enable), .rf_write_addr(rf_write_addr), .rf_data_in(rf_data_in),
        .pending(pending)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock: compare DUT against the model mid-cycle, then advance the model over the edge.
    task automatic cycle();
        logic frc, e_r0, e_r1, e_iss;
        logic [31:0] n_pend;
        @(negedge clk);
        frc   = (m_lost == 4) && src1_valid;
        e_r0  = !rst && src0_valid && !frc;
        e_r1  = !rst && src1_valid && !e_r0;
        e_iss = !rst && (iss_rd == 5'd0 || !m_pending[iss_rd]);
        d_r0 = src0_ready; d_r1 = src1_ready; d_iss = iss_ready;
        chk("src0_ready", src0_ready, e_r0);
        chk("src1_ready", src1_ready, e_r1);
        chk("iss_ready", iss_ready, e_iss);
        chk("rf_write_enable", rf_write_enable, m_wen);
        if (m_wen) begin
            chk("rf_write_addr", rf_write_addr, m_waddr);
            chk("rf_data_in", rf_data_in, m_wdata);
        end
        chk("pending", pending, m_pending);
        acc0 = e_r0; acc1 = e_r1;
        if (rst) begin
            m_pending = '0; m_lost = 0; m_wen = 0;
        end else begin
            n_pend = m_pending;
            if (m_wen) n_pend[m_waddr] = 1'b0;
            if (iss_valid && e_iss && iss_rd != 5'd0) n_pend[iss_rd] = 1'b1;
            m_pending = n_pend;
            if (e_r1) m_lost = 0;
            else if (e_r0 && src1_valid && m_lost < 4) m_lost++;
            if (e_r0) begin
                m_wen = (src0_rd != 5'd0); m_waddr = src0_rd; m_wdata = src0_data;
            end else if (e_r1) begin
                m_wen = (src1_rd != 5'd0); m_waddr = src1_rd; m_wdata = src1_data;
            end else begin
                m_wen = 1'b0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic gen();
        if (!src0_valid || acc0) begin
            src0_valid = ($urandom_range(0, 3) != 0);
            src0_rd    = 5'($urandom_range(0, 7));
            src0_data  = $urandom;
        end
        if (!src1_valid || acc1) begin
            src1_valid = ($urandom_range(0, 1) != 0);
            src1_rd    = 5'($urandom_range(0, 7));
            src1_data  = $urandom;
        end
        iss_valid = ($urandom_range(0, 1) != 0);
        iss_rd    = 5'($urandom_range(0, 7));
        rst       = ($urandom_range(0, 149) == 0);
    endtask

    initial begin
        m_pending = '0; m_lost = 0; m_wen = 0; m_waddr = '0; m_wdata = '0;
        acc0 = 0; acc1 = 0;
        rst = 1;
        src0_valid = 1; src0_rd = 5'd1; src0_data = 32'h11;
        src1_valid = 1; src1_rd = 5'd2; src1_data = 32'h22;
        iss_valid  = 1; iss_rd  = 5'd3;
        repeat (3) cycle();
        chk("t1_pending", pending, 32'h0);
        chk("t1_wen", rf_write_enable, 1'b0);

        rst = 0; src1_valid = 0; iss_valid = 0;
        src0_rd = 5'd5; src0_data = 32'hDEADBEEF;
        cycle();
        chk("t2_wen", rf_write_enable, 1'b1);
        chk("t2_addr", rf_write_addr, 5'd5);
        chk("t2_data", rf_data_in, 32'hDEADBEEF);
        src0_valid = 0;
        cycle();
        chk("t2_wen_once", rf_write_enable, 1'b0);

        iss_valid = 1; iss_rd = 5'd7;
        cycle();
        chk("t3_pend_set", pending[7], 1'b1);
        cycle();
        chk("t3_iss_stall", d_iss, 1'b0);
        src0_valid = 1; src0_rd = 5'd7; src0_data = 32'h7777;
        cycle();
        src0_valid = 0;
        cycle();
        chk("t3_stall_on_strobe", d_iss, 1'b0);
        chk("t3_pend_clr", pending[7], 1'b0);
        cycle();
        chk("t3_iss_go", d_iss, 1'b1);
        iss_valid = 0;

        src0_valid = 1; src0_rd = 5'd1;
        src1_valid = 1; src1_rd = 5'd2; src1_data = 32'hCAFE0002;
        for (int i = 0; i < 6; i++) begin
            src0_data = 32'h100 + 32'(i);
            cycle();
            chk("t4_grant", {d_r0, d_r1}, (i == 4) ? 2'b01 : 2'b10);
            if (i == 4) src1_valid = 0;
        end
        src0_valid = 0;

        src1_valid = 1; src1_rd = 5'd0; src1_data = 32'h1234;
        cycle();
        chk("t5_ready", d_r1, 1'b1);
        src1_valid = 0;
        chk("t5_no_strobe", rf_write_enable, 1'b0);
        cycle();

        iss_valid = 1; iss_rd = 5'd3;
        cycle();
        iss_valid = 0; src0_valid = 1; src0_rd = 5'd3; src0_data = 32'hA3;
        cycle();
        iss_valid = 1; src0_data = 32'hB3;
        cycle();
        chk("t6_iss_stall", d_iss, 1'b0);
        src0_valid = 0;
        cycle();
        chk("t6_iss_go", d_iss, 1'b1);
        chk("t6_set_wins", pending[3], 1'b1);
        iss_valid = 0; src0_valid = 1; src0_rd = 5'd9; src0_data = 32'h99; rst = 1;
        cycle();
        chk("t6_rst_no_strobe", rf_write_enable, 1'b0);
        chk("t6_rst_pending", pending, 32'h0);
        rst = 0; src0_valid = 0;
        cycle();

        for (int c = 0; c < 3000; c++) begin
            gen();
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
